// File: rtl/frame_buf_multi.sv
// Multi-bank frame buffer: the producer fills banks round-robin and the consumer drains
// committed banks in the same order, so whole-frame capture and playback overlap.
module frame_buf_multi #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned FRAME_DEPTH = 1 << ADDR_WIDTH,
  parameter int unsigned BUF_WIDTH   = 1,
  parameter int unsigned NUM_BUFS    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_data_valid,
  output logic                  frame_wr_done,
  output logic                  frame_rd_done,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [BUF_WIDTH-1:0]  wr_buf_idx,
  output logic [BUF_WIDTH-1:0]  rd_buf_idx
);

  localparam int unsigned           MemWords = NUM_BUFS * FRAME_DEPTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FRAME_DEPTH - 1);
  localparam logic [BUF_WIDTH-1:0]  LastBuf  = BUF_WIDTH'(NUM_BUFS - 1);
  localparam logic [BUF_WIDTH:0]    FullCnt  = (BUF_WIDTH + 1)'(NUM_BUFS);

  logic [DATA_WIDTH-1:0] mem [MemWords];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [BUF_WIDTH:0]    frame_cnt;

  logic wr_req;
  logic wr_accept;
  logic rd_accept;
  logic commit;
  logic frame_release;

  // Accept decisions use the pre-edge frame count, so a write while full is dropped even
  // when a release happens on the same edge.
  assign wr_req        = !wr_en_in;
  assign wr_accept     = wr_req && (frame_cnt < FullCnt);
  assign rd_accept     = !rd_en_in && (frame_cnt != '0);
  assign commit        = wr_accept && (wr_addr == LastAddr);
  assign frame_release = rd_accept && (rd_addr == LastAddr);

  assign full  = (frame_cnt == FullCnt);
  assign empty = (frame_cnt == '0);

  // Storage is not reset; only committed banks are ever read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_buf_idx, wr_addr}] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr       <= '0;
      rd_addr       <= '0;
      wr_buf_idx    <= '0;
      rd_buf_idx    <= '0;
      frame_cnt     <= '0;
      data_out      <= '0;
      rd_data_valid <= 1'b0;
      frame_wr_done <= 1'b0;
      frame_rd_done <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      rd_data_valid <= rd_accept;
      frame_wr_done <= commit;
      frame_rd_done <= frame_release;

      if (wr_req && !wr_accept) begin
        overflow <= 1'b1;
      end

      if (wr_accept) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (commit) begin
        wr_addr    <= '0;
        wr_buf_idx <= (wr_buf_idx == LastBuf) ? '0 : wr_buf_idx + 1'b1;
      end

      if (rd_accept) begin
        data_out <= mem[{rd_buf_idx, rd_addr}];
        rd_addr  <= rd_addr + 1'b1;
      end
      if (frame_release) begin
        rd_addr    <= '0;
        rd_buf_idx <= (rd_buf_idx == LastBuf) ? '0 : rd_buf_idx + 1'b1;
      end

      unique case ({commit, frame_release})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_multi.sv
// Bench for frame_buf_multi: directed and random traffic checked every cycle against a
// queue-based frame model.
module tb_frame_buf_multi;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int NB    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en_in = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          rd_en_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          rd_data_valid, frame_wr_done, frame_rd_done, full, empty, overflow;
  logic [0:0]    wr_buf_idx, rd_buf_idx;

  int vectors = 0;
  int miscompares = 0;

  frame_buf_multi #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FRAME_DEPTH(DEPTH),
    .BUF_WIDTH  (1),
    .NUM_BUFS   (NB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en_in     (wr_en_in),
    .data_in      (data_in),
    .rd_en_in     (rd_en_in),
    .data_out     (data_out),
    .rd_data_valid(rd_data_valid),
    .frame_wr_done(frame_wr_done),
    .frame_rd_done(frame_rd_done),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .wr_buf_idx   (wr_buf_idx),
    .rd_buf_idx   (rd_buf_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {data_out, rd_data_valid, frame_wr_done, frame_rd_done, full, empty, overflow,
                wr_buf_idx, rd_buf_idx};

  // Model: committed unread words in order, the partial frame being written, frame counts.
  logic [DW-1:0] m_words[$];
  logic [DW-1:0] m_cur[$];
  int            m_nframes, m_rd_pos, m_commits, m_releases;
  logic [DW-1:0] m_data;
  logic          m_valid, m_wr_done, m_rd_done, m_ovf;

  task automatic model_reset();
    m_words.delete();
    m_cur.delete();
    m_nframes = 0; m_rd_pos = 0; m_commits = 0; m_releases = 0;
    m_data = '0; m_valid = 0; m_wr_done = 0; m_rd_done = 0; m_ovf = 0;
  endtask

  function automatic logic [15:0] exp_vec();
    logic wi, ri;
    wi = (m_commits % NB) != 0;
    ri = (m_releases % NB) != 0;
    return {m_data, m_valid, m_wr_done, m_rd_done, m_nframes == NB, m_nframes == 0, m_ovf,
            wi, ri};
  endfunction

  // Drive one cycle of requests (0 = request), then advance the model past that edge.
  task automatic step(input logic wn, input logic [DW-1:0] d, input logic rn);
    int  pre;
    logic do_commit;
    wr_en_in = wn; data_in = d; rd_en_in = rn;
    @(posedge clk);
    #1;
    pre = m_nframes;
    do_commit = 0;
    m_valid = 0; m_wr_done = 0; m_rd_done = 0;
    if (!wn) begin
      if (pre < NB) begin
        m_cur.push_back(d);
        if (m_cur.size() == DEPTH) do_commit = 1;
      end else begin
        m_ovf = 1;
      end
    end
    if (!rn && pre > 0) begin
      m_data  = m_words.pop_front();
      m_valid = 1;
      m_rd_pos++;
      if (m_rd_pos == DEPTH) begin
        m_rd_pos = 0; m_rd_done = 1; m_nframes--; m_releases++;
      end
    end
    if (do_commit) begin
      foreach (m_cur[k]) m_words.push_back(m_cur[k]);
      m_cur.delete();
      m_nframes++; m_commits++; m_wr_done = 1;
    end
    wr_en_in = 1'b1; rd_en_in = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (obs !== 16'h0008) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", obs, 16'h0008);
    end
    @(negedge clk);
    reset = 1'b1;
    // Reads with nothing committed are ignored.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hAA, 1'b0);
      vectors++;
      if (obs !== exp_vec() || rd_data_valid !== 1'b0 || data_out !== 8'h00) begin
        miscompares++;
        $display("FAIL read_when_empty[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h10 + 8'(i), 1'b1);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_write[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (frame_wr_done !== 1'b1 || empty !== 1'b0 || wr_buf_idx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_commit: got done=%b empty=%b wr_idx=%b expected 1 0 1",
               frame_wr_done, empty, wr_buf_idx);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'h00, 1'b0);
      vectors++;
      if (obs !== exp_vec() || data_out !== 8'h10 + 8'(i) || rd_data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL single_read[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (frame_rd_done !== 1'b1 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rd_done: got done=%b empty=%b expected 1 1", frame_rd_done, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      step(1'b0, 8'h20 + 8'(i), 1'b1);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL fill_write[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    step(1'b0, 8'hFF, 1'b1);
    vectors++;
    if (obs !== exp_vec() || full !== 1'b1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drop: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      step(1'b1, 8'h00, 1'b0);
      vectors++;
      if (obs !== exp_vec() || (i < 2 * DEPTH && data_out !== 8'h20 + 8'(i))) begin
        miscompares++;
        $display("FAIL drain_read[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_simul_commit_release();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h40 + 8'(i), 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h50 + 8'(i), 1'b0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL simul[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (rd_buf_idx !== 1'b1 || wr_buf_idx !== 1'b0 || full !== 1'b0 || empty !== 1'b0 ||
        frame_wr_done !== 1'b1 || frame_rd_done !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_indices: got rd=%b wr=%b full=%b empty=%b expected 1 0 0 0",
               rd_buf_idx, wr_buf_idx, full, empty);
    end
  endtask

  task automatic test_mid_frame_reset();
    apply_reset();
    step(1'b0, 8'h77, 1'b1);
    step(1'b0, 8'h78, 1'b1);
    reset = 1'b0;
    #2;
    model_reset();
    vectors++;
    if (obs !== 16'h0008) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs, 16'h0008);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h30 + 8'(i), 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'h00, 1'b0);
      vectors++;
      if (obs !== exp_vec() || data_out !== 8'h30 + 8'(i)) begin
        miscompares++;
        $display("FAIL post_reset_read[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 5 * DEPTH + 8; i++) begin
      step((i < 5 * DEPTH) ? 1'b0 : 1'b1, 8'($urandom), 1'b0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (overflow !== 1'b0 || empty !== 1'b1 || wr_buf_idx !== 1'b1 || rd_buf_idx !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_end: got ovf=%b empty=%b wr=%b rd=%b expected 0 1 1 1",
               overflow, empty, wr_buf_idx, rd_buf_idx);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_simul_commit_release();
    test_mid_frame_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
